// File: rtl/wb_dma.sv
// Single-channel memory-to-memory DMA: a Wishbone register slave programs SRC/DST/LEN,
// and a Wishbone master copies LEN words, one read then one write per word.
module wb_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic        intr
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_NEXT} state_t;
  state_t r_state, w_next;

  logic [31:0] r_src, r_dst, r_wsrc, r_wdst, r_data, r_dat_o;
  logic [15:0] r_len, r_wcnt;
  logic        r_irq_en, r_done, r_err, r_ack, r_hold;

  logic        w_acc, w_wr, w_ctrl_wr, w_busy, w_start, w_go;
  logic        w_live, w_mack, w_merr, w_mrty, w_last;
  logic [31:0] w_ctrl, w_rdat, w_wmerge;
  logic        w_unused;

  assign w_unused  = ^{wb_adr_i[31:4], wb_adr_i[1:0]};
  assign w_acc     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_ctrl_wr = w_wr & (wb_adr_i[3:2] == 2'd3) & wb_sel_i[0];
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_ctrl_wr & wb_dat_i[0] & ~w_busy;
  assign w_go      = w_start & (r_len != 16'd0);
  // r_hold masks the bus for one cycle after a retry; the access then re-issues unchanged
  assign w_live    = ((r_state == S_READ) || (r_state == S_WRITE)) & ~r_hold;
  assign w_merr    = w_live & m_err_i;
  assign w_mack    = w_live & m_ack_i & ~m_err_i;
  assign w_mrty    = w_live & m_rty_i & ~m_ack_i & ~m_err_i;
  assign w_last    = (r_state == S_NEXT) && (r_wcnt == 16'd1);
  assign w_ctrl    = {27'd0, r_err, r_irq_en, r_done, w_busy, 1'b0};

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat_o;
  assign intr      = r_done & r_irq_en;

  always_comb begin
    case (wb_adr_i[3:2])
      2'd0:    w_rdat = r_src;
      2'd1:    w_rdat = r_dst;
      2'd2:    w_rdat = {16'd0, r_len};
      default: w_rdat = w_ctrl;
    endcase
    w_wmerge = w_rdat;
    for (int b = 0; b < 4; b++)
      if (wb_sel_i[b]) w_wmerge[b*8 +: 8] = wb_dat_i[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = 4'h0;
    m_adr_o = 32'd0;
    m_dat_o = 32'd0;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_READ;
      S_READ:  if (w_merr) w_next = S_IDLE; else if (w_mack) w_next = S_WRITE;
      S_WRITE: if (w_merr) w_next = S_IDLE; else if (w_mack) w_next = S_NEXT;
      default: w_next = w_last ? S_IDLE : S_READ;
    endcase
    if (w_live) begin
      m_cyc_o = 1'b1;
      m_stb_o = 1'b1;
      m_sel_o = 4'hF;
      if (r_state == S_WRITE) begin
        m_we_o  = 1'b1;
        m_adr_o = r_wdst;
        m_dat_o = r_data;
      end else begin
        m_adr_o = r_wsrc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src <= '0; r_dst <= '0; r_len <= '0;
      r_wsrc <= '0; r_wdst <= '0; r_wcnt <= '0; r_data <= '0;
      r_irq_en <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
      r_ack <= 1'b0; r_dat_o <= '0; r_hold <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_dat_o <= (w_acc && !wb_we_i) ? w_rdat : 32'd0;
      if (w_wr && !w_busy) begin
        case (wb_adr_i[3:2])
          2'd0:    r_src <= {w_wmerge[31:2], 2'b00};
          2'd1:    r_dst <= {w_wmerge[31:2], 2'b00};
          2'd2:    r_len <= w_wmerge[15:0];
          default: ;
        endcase
      end
      if (w_ctrl_wr) begin
        r_irq_en <= wb_dat_i[3];
        if (wb_dat_i[2]) r_done <= 1'b0;
        if (wb_dat_i[4]) r_err  <= 1'b0;
      end
      // hardware set comes after the write-1-clear so it wins on a collision
      if ((w_start && r_len == 16'd0) || w_last) r_done <= 1'b1;
      if (w_merr) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end
      r_hold <= w_mrty;
      if (w_go) begin
        r_wsrc <= r_src;
        r_wdst <= r_dst;
        r_wcnt <= r_len;
      end
      if (r_state == S_READ && w_mack) r_data <= m_dat_i;
      if (r_state == S_NEXT) begin
        r_wsrc <= r_wsrc + 32'd4;
        r_wdst <= r_wdst + 32'd4;
        r_wcnt <= r_wcnt - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_dma.sv
// Randomized bench for wb_dma: a memory model answers the master port, and scoreboards
// check DMA writes and register reads against expectations derived from a copy-list model.
module tb_wb_dma;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i = '0;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic        m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;
  logic        intr;

  wb_dma dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i), .intr(intr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
  typedef struct { bit rd; logic [31:0] dat; } acc_t;

  wr_t         exp_wr[$];
  acc_t        exp_acc[$];
  logic [31:0] mem [bit [31:0]];
  int nchk = 0, npass = 0, n_wr = 0, n_cyc = 0, rd_cnt = 0, err_at = 0;
  bit rty_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Memory-side responder and DMA write scoreboard
  always @(negedge clk) begin
    wr_t e;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_dat_i = '0;
    if (!reset && m_cyc_o) n_cyc++;
    if (!reset && m_cyc_o && m_stb_o) begin
      if (m_sel_o !== 4'hF) chk("m_sel", {28'd0, m_sel_o}, 32'hF);
      if (!m_we_o && err_at != 0 && rd_cnt + 1 == err_at) begin
        m_err_i = 1'b1;
        err_at  = 0;
      end else begin
        int r;
        r = $urandom_range(0, 7);
        if (r < 2) begin
        end else if (r == 2 && rty_ok) m_rty_i = 1'b1;
        else begin
          m_ack_i = 1'b1;
          if (!m_we_o) begin
            rd_cnt++;
            m_dat_i = mem.exists(m_adr_o) ? mem[m_adr_o] : 32'd0;
          end else begin
            n_wr++;
            if (exp_wr.size() == 0) begin
              nchk++;
              $display("FAIL dma_wr: unexpected write adr %h dat %h", m_adr_o, m_dat_o);
            end else begin
              e = exp_wr.pop_front();
              chk("dma_wr_adr", m_adr_o, e.adr);
              chk("dma_wr_dat", m_dat_o, e.dat);
            end
            mem[m_adr_o] = m_dat_o;
          end
        end
      end
    end
  end

  // Register-read scoreboard
  always @(negedge clk) begin
    acc_t a;
    if (wb_ack_o) begin
      if (exp_acc.size() == 0) begin
        nchk++;
        $display("FAIL wb_ack: unexpected ack, got 1 expected 0");
      end else begin
        a = exp_acc.pop_front();
        if (a.rd) chk("wb_rdata", wb_dat_o, a.dat);
      end
    end
  end

  task automatic wb_acc(input bit we, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] sel, input logic [31:0] exp);
    acc_t e;
    e.rd = !we; e.dat = exp;
    exp_acc.push_back(e);
    @(negedge clk);
    wb_adr_i = {28'd0, a, 2'b00}; wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk);
    chk("ack_1cyc", {31'd0, wb_ack_o}, 32'd1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    chk("ack_pulse", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    wb_acc(1'b1, a, d, 4'hF, 32'd0);
  endtask

  task automatic wb_rd(input logic [1:0] a, input logic [31:0] exp);
    wb_acc(1'b0, a, 32'd0, 4'hF, exp);
  endtask

  task automatic load(input logic [31:0] src, dst, input int len, input int nexp);
    for (int i = 0; i < len; i++) begin
      wr_t w;
      mem[src + 32'(4*i)] = $urandom;
      w.adr = dst + 32'(4*i);
      w.dat = mem[src + 32'(4*i)];
      if (i < nexp) exp_wr.push_back(w);
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 3000 && exp_wr.size() != 0; k++) @(negedge clk);
    chk(nm, exp_wr.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [31:0] src, dst, input logic [15:0] len, input bit irq);
    load(src, dst, int'(len), int'(len));
    wb_wr(2'd0, src); wb_wr(2'd1, dst); wb_wr(2'd2, {16'd0, len});
    wb_wr(2'd3, irq ? 32'h9 : 32'h1);
    drain("xfer_drain");
    wb_rd(2'd3, irq ? 32'hC : 32'h4);
    chk("xfer_intr", {31'd0, intr}, {31'd0, irq});
    wb_wr(2'd3, 32'h4);
    wb_rd(2'd3, 32'h0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_mctl", {28'd0, m_cyc_o, m_stb_o, m_we_o, intr}, 32'd0);
    chk("rst_madr", m_adr_o, 32'd0);
    chk("rst_mdat", m_dat_o, 32'd0);
    chk("rst_msel", {28'd0, m_sel_o}, 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) wb_rd(2'(r), 32'd0);

    // basic 4-word copy with interrupt
    run_xfer(32'h4000_0100, 32'h4000_0200, 16'd4, 1'b1);
    wb_rd(2'd0, 32'h4000_0100);

    // zero length: done without bus traffic
    n0 = n_cyc;
    wb_wr(2'd2, 32'd0);
    wb_wr(2'd3, 32'h9);
    chk("len0_intr", {31'd0, intr}, 32'd1);
    wb_rd(2'd3, 32'hC);
    chk("len0_nocyc", n_cyc - n0, 32'd0);
    wb_wr(2'd3, 32'h4);
    chk("len0_intr_clr", {31'd0, intr}, 32'd0);
    wb_rd(2'd3, 32'h0);

    // randomized copies with retries and wait states, plus address wrap
    rty_ok = 1'b1;
    for (int t = 0; t < 4; t++)
      run_xfer(32'h1000_0000 + 32'($urandom_range(0, 255) * 4),
               32'h2000_0000 + 32'($urandom_range(0, 255) * 4),
               16'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
    run_xfer(32'hFFFF_FFF8, 32'h2800_0000, 16'd3, 1'b0);

    // bus error on the second read
    rty_ok = 1'b0; rd_cnt = 0; err_at = 2; n0 = n_wr;
    load(32'h6000_0000, 32'h6800_0000, 3, 1);
    wb_wr(2'd0, 32'h6000_0000); wb_wr(2'd1, 32'h6800_0000); wb_wr(2'd2, 32'd3);
    wb_wr(2'd3, 32'h1);
    for (int k = 0; k < 500 && err_at != 0; k++) @(negedge clk);
    chk("err_seen", err_at, 32'd0);
    repeat (3) @(negedge clk);
    chk("err_cyc_low", {31'd0, m_cyc_o}, 32'd0);
    chk("err_one_word", n_wr - n0, 32'd1);
    chk("err_q_empty", exp_wr.size(), 32'd0);
    wb_rd(2'd3, 32'h14);
    wb_wr(2'd3, 32'h14);
    wb_rd(2'd3, 32'h0);

    // register writes and START while busy are ignored
    rty_ok = 1'b1;
    load(32'h3000_0000, 32'h3800_0000, 8, 8);
    wb_wr(2'd0, 32'h3000_0000); wb_wr(2'd1, 32'h3800_0000); wb_wr(2'd2, 32'd8);
    wb_wr(2'd3, 32'h1);
    wb_wr(2'd0, 32'h1234_567B);
    wb_wr(2'd3, 32'h1);
    wb_rd(2'd0, 32'h3000_0000);
    wb_rd(2'd3, 32'h2);
    drain("busy_drain");
    wb_rd(2'd3, 32'h4);
    wb_wr(2'd3, 32'h4);

    // address alignment, LEN width and byte lanes
    wb_wr(2'd0, 32'hFFFF_FFFF);
    wb_rd(2'd0, 32'hFFFF_FFFC);
    wb_wr(2'd1, 32'hFFFF_FFFF);
    wb_rd(2'd1, 32'hFFFF_FFFC);
    wb_wr(2'd2, 32'hFFFF_FFFF);
    wb_rd(2'd2, 32'h0000_FFFF);
    wb_wr(2'd0, 32'h0);
    wb_acc(1'b1, 2'd0, 32'hAABB_CCDD, 4'b0101, 32'd0);
    wb_rd(2'd0, 32'h00BB_00DC);

    // reset in the middle of word 2 of 5
    n0 = n_wr;
    load(32'h5000_0000, 32'h5800_0000, 5, 5);
    wb_wr(2'd0, 32'h5000_0000); wb_wr(2'd1, 32'h5800_0000); wb_wr(2'd2, 32'd5);
    wb_wr(2'd3, 32'h9);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 500 && !hit; k++) begin
        @(posedge clk); #1;
        if (n_wr - n0 >= 1 && m_cyc_o && m_we_o) hit = 1'b1;
      end
      chk("rst_mid_reached", {31'd0, hit}, 32'd1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_cyc", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
    reset = 1'b0;
    exp_wr.delete();
    chk("rst_mid_words", n_wr - n0, 32'd1);
    chk("rst_mid_intr", {31'd0, intr}, 32'd0);
    for (int r = 0; r < 4; r++) wb_rd(2'(r), 32'd0);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
